// File: rtl/bcd_mod_counter_if.sv
// Control and digit bus of one two-digit BCD counter stage.
// The driver side uses master, the counter itself uses slave.
interface bcd_mod_counter_if;
   logic       tick;
   logic       up_down;
   logic       hold;
   logic       load_enable;
   logic [3:0] set_value1;
   logic [3:0] set_value10;
   logic [3:0] dec1;
   logic [3:0] dec10;
   logic       wrap;
   logic       is_zero;
   logic       load_err;

   modport master (
      output tick, up_down, hold, load_enable, set_value1, set_value10,
      input  dec1, dec10, wrap, is_zero, load_err
   );

   modport slave (
      input  tick, up_down, hold, load_enable, set_value1, set_value10,
      output dec1, dec10, wrap, is_zero, load_err
   );
endinterface

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD up/down counter modulo MODULUS with preload, hold and a
// one-cycle wrap pulse that drives the tick of the next cascaded stage.
module bcd_mod_counter #(
   parameter int MODULUS = 60,
   parameter int INIT    = 0
) (
   input logic            clk,
   input logic            reset_p,
   bcd_mod_counter_if.slave bus
);

   localparam logic [3:0] INIT1   = 4'(INIT % 10);
   localparam logic [3:0] INIT10  = 4'(INIT / 10);
   localparam logic [3:0] TOP1    = 4'((MODULUS - 1) % 10);
   localparam logic [3:0] TOP10   = 4'((MODULUS - 1) / 10);
   localparam logic [7:0] TOP_VAL = 8'(MODULUS - 1);
   localparam logic [7:0] MOD_VAL = 8'(MODULUS);

   logic [3:0] dec1_reg, dec1_next;
   logic [3:0] dec10_reg, dec10_next;
   logic       wrap_reg, wrap_next;
   logic       load_err_reg, load_err_next;

   logic [7:0] count_val;
   logic [7:0] set_val;
   logic       set_ok;
   logic       at_top;
   logic       at_zero;

   // Set digits can be up to 15 each, so the binary value needs 8 bits.
   assign count_val = 8'(dec10_reg) * 8'd10 + 8'(dec1_reg);
   assign set_val   = 8'(bus.set_value10) * 8'd10 + 8'(bus.set_value1);
   assign set_ok    = (bus.set_value1 <= 4'd9) && (bus.set_value10 <= 4'd9)
                      && (set_val < MOD_VAL);
   assign at_top    = (count_val == TOP_VAL);
   assign at_zero   = (dec1_reg == 4'd0) && (dec10_reg == 4'd0);

   always_comb begin
      dec1_next     = dec1_reg;
      dec10_next    = dec10_reg;
      wrap_next     = 1'b0;
      load_err_next = 1'b0;
      if (bus.load_enable) begin
         // A load always swallows a coincident tick, even a wrapping one.
         if (set_ok) begin
            dec1_next  = bus.set_value1;
            dec10_next = bus.set_value10;
         end else begin
            load_err_next = 1'b1;
         end
      end else if (bus.tick && !bus.hold) begin
         if (bus.up_down) begin
            if (at_top) begin
               dec1_next  = 4'd0;
               dec10_next = 4'd0;
               wrap_next  = 1'b1;
            end else if (dec1_reg == 4'd9) begin
               dec1_next  = 4'd0;
               dec10_next = dec10_reg + 4'd1;
            end else begin
               dec1_next  = dec1_reg + 4'd1;
            end
         end else begin
            if (at_zero) begin
               dec1_next  = TOP1;
               dec10_next = TOP10;
               wrap_next  = 1'b1;
            end else if (dec1_reg == 4'd0) begin
               dec1_next  = 4'd9;
               dec10_next = dec10_reg - 4'd1;
            end else begin
               dec1_next  = dec1_reg - 4'd1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset_p) begin
      if (reset_p) begin
         dec1_reg     <= INIT1;
         dec10_reg    <= INIT10;
         wrap_reg     <= 1'b0;
         load_err_reg <= 1'b0;
      end else begin
         dec1_reg     <= dec1_next;
         dec10_reg    <= dec10_next;
         wrap_reg     <= wrap_next;
         load_err_reg <= load_err_next;
      end
   end

   assign bus.dec1     = dec1_reg;
   assign bus.dec10    = dec10_reg;
   assign bus.wrap     = wrap_reg;
   assign bus.load_err = load_err_reg;
   assign bus.is_zero  = at_zero;

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Directed bench: mod-60 and mod-24 (INIT=7) counters plus a mod-60 upper
// stage chained on the mod-60 wrap output.
module tb_bcd_mod_counter;

   logic clk = 1'b0;
   logic reset_p;
   int   checks   = 0;
   int   failures = 0;

   bcd_mod_counter_if bus60 ();
   bcd_mod_counter_if bus24 ();
   bcd_mod_counter_if bus_min ();

   bcd_mod_counter #(.MODULUS(60), .INIT(0)) u_sec (
      .clk(clk), .reset_p(reset_p), .bus(bus60.slave));
   bcd_mod_counter #(.MODULUS(24), .INIT(7)) u_hour (
      .clk(clk), .reset_p(reset_p), .bus(bus24.slave));
   bcd_mod_counter #(.MODULUS(60), .INIT(0)) u_min (
      .clk(clk), .reset_p(reset_p), .bus(bus_min.slave));

   assign bus_min.tick    = bus60.wrap;
   assign bus_min.up_down = bus60.up_down;

   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time exceeded 300000");
      $fatal(1, "watchdog expired");
   end

   // One transaction on counter sel (0 = mod 60, 1 = mod 24), called at a negedge.
   task automatic drive(input int sel, input logic ld, input logic tk,
                        input logic [3:0] tens, input logic [3:0] ones);
      if (sel == 0) begin
         bus60.load_enable = ld; bus60.tick = tk;
         bus60.set_value10 = tens; bus60.set_value1 = ones;
      end else begin
         bus24.load_enable = ld; bus24.tick = tk;
         bus24.set_value10 = tens; bus24.set_value1 = ones;
      end
      @(negedge clk);
      bus60.load_enable = 1'b0; bus60.tick = 1'b0;
      bus24.load_enable = 1'b0; bus24.tick = 1'b0;
      $display("txn sel=%0d load=%b tick=%b set=%h/%h | m60=%h%h w=%b e=%b | m24=%h%h w=%b e=%b",
               sel, ld, tk, tens, ones, bus60.dec10, bus60.dec1, bus60.wrap,
               bus60.load_err, bus24.dec10, bus24.dec1, bus24.wrap, bus24.load_err);
   endtask

   task automatic pulse_reset();
      reset_p = 1'b1;
      #1;
      reset_p = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset_p = 1'b1;
      @(negedge clk);
      checks++; if ({bus60.dec10, bus60.dec1, bus60.is_zero, bus60.wrap, bus60.load_err} !== {8'h00, 3'b100}) begin
         failures++; $display("FAIL reset_m60: got %h%h z=%b w=%b e=%b want 00 z=1 w=0 e=0",
            bus60.dec10, bus60.dec1, bus60.is_zero, bus60.wrap, bus60.load_err); end
      checks++; if ({bus24.dec10, bus24.dec1, bus24.is_zero, bus24.wrap, bus24.load_err} !== {8'h07, 3'b000}) begin
         failures++; $display("FAIL reset_m24: got %h%h z=%b w=%b e=%b want 07 z=0 w=0 e=0",
            bus24.dec10, bus24.dec1, bus24.is_zero, bus24.wrap, bus24.load_err); end
      reset_p = 1'b0;
      @(negedge clk);
      checks++; if ({bus60.dec10, bus60.dec1, bus24.dec10, bus24.dec1} !== 16'h0007) begin
         failures++; $display("FAIL reset_idle: got m60=%h%h m24=%h%h want 00 07",
            bus60.dec10, bus60.dec1, bus24.dec10, bus24.dec1); end
   endtask

   task automatic test_up_wrap();
      bus60.up_down = 1'b1;
      drive(0, 1'b1, 1'b0, 4'd5, 4'd8);
      checks++; if ({bus60.dec10, bus60.dec1, bus60.load_err} !== {8'h58, 1'b0}) begin
         failures++; $display("FAIL up_load58: got %h%h e=%b want 58 e=0", bus60.dec10, bus60.dec1, bus60.load_err); end
      drive(0, 1'b0, 1'b1, 4'd0, 4'd0);
      checks++; if ({bus60.dec10, bus60.dec1, bus60.wrap, bus60.is_zero} !== {8'h59, 2'b00}) begin
         failures++; $display("FAIL up_59: got %h%h w=%b z=%b want 59 w=0 z=0",
            bus60.dec10, bus60.dec1, bus60.wrap, bus60.is_zero); end
      drive(0, 1'b0, 1'b1, 4'd0, 4'd0);
      checks++; if ({bus60.dec10, bus60.dec1, bus60.wrap, bus60.is_zero} !== {8'h00, 2'b11}) begin
         failures++; $display("FAIL up_wrap: got %h%h w=%b z=%b want 00 w=1 z=1",
            bus60.dec10, bus60.dec1, bus60.wrap, bus60.is_zero); end
      drive(0, 1'b0, 1'b0, 4'd0, 4'd0);
      checks++; if ({bus60.dec10, bus60.dec1, bus60.wrap} !== {8'h00, 1'b0}) begin
         failures++; $display("FAIL up_wrap_end: got %h%h w=%b want 00 w=0", bus60.dec10, bus60.dec1, bus60.wrap); end
   endtask

   task automatic test_down_wrap();
      pulse_reset();
      bus60.up_down = 1'b0;
      drive(0, 1'b0, 1'b1, 4'd0, 4'd0);
      checks++; if ({bus60.dec10, bus60.dec1, bus60.wrap, bus60.is_zero} !== {8'h59, 2'b10}) begin
         failures++; $display("FAIL down_wrap: got %h%h w=%b z=%b want 59 w=1 z=0",
            bus60.dec10, bus60.dec1, bus60.wrap, bus60.is_zero); end
      drive(0, 1'b0, 1'b1, 4'd0, 4'd0);
      checks++; if ({bus60.dec10, bus60.dec1, bus60.wrap} !== {8'h58, 1'b0}) begin
         failures++; $display("FAIL down_58: got %h%h w=%b want 58 w=0", bus60.dec10, bus60.dec1, bus60.wrap); end
   endtask

   task automatic test_carry_borrow();
      bus60.up_down = 1'b1;
      drive(0, 1'b1, 1'b0, 4'd1, 4'd9);
      drive(0, 1'b0, 1'b1, 4'd0, 4'd0);
      checks++; if ({bus60.dec10, bus60.dec1, bus60.wrap} !== {8'h20, 1'b0}) begin
         failures++; $display("FAIL carry_19_20: got %h%h w=%b want 20 w=0", bus60.dec10, bus60.dec1, bus60.wrap); end
      bus60.up_down = 1'b0;
      drive(0, 1'b0, 1'b1, 4'd0, 4'd0);
      checks++; if ({bus60.dec10, bus60.dec1, bus60.wrap} !== {8'h19, 1'b0}) begin
         failures++; $display("FAIL borrow_20_19: got %h%h w=%b want 19 w=0", bus60.dec10, bus60.dec1, bus60.wrap); end
   endtask

   task automatic test_hour();
      bus24.up_down = 1'b1;
      drive(1, 1'b1, 1'b0, 4'd2, 4'd3);
      checks++; if ({bus24.dec10, bus24.dec1} !== 8'h23) begin
         failures++; $display("FAIL hour_load23: got %h%h want 23", bus24.dec10, bus24.dec1); end
      drive(1, 1'b0, 1'b1, 4'd0, 4'd0);
      checks++; if ({bus24.dec10, bus24.dec1, bus24.wrap, bus24.is_zero} !== {8'h00, 2'b11}) begin
         failures++; $display("FAIL hour_up_wrap: got %h%h w=%b z=%b want 00 w=1 z=1",
            bus24.dec10, bus24.dec1, bus24.wrap, bus24.is_zero); end
      bus24.up_down = 1'b0;
      drive(1, 1'b0, 1'b1, 4'd0, 4'd0);
      checks++; if ({bus24.dec10, bus24.dec1, bus24.wrap, bus24.is_zero} !== {8'h23, 2'b10}) begin
         failures++; $display("FAIL hour_down_wrap: got %h%h w=%b z=%b want 23 w=1 z=0",
            bus24.dec10, bus24.dec1, bus24.wrap, bus24.is_zero); end
   endtask

   task automatic test_invalid_load();
      drive(0, 1'b1, 1'b0, 4'd1, 4'd2);
      checks++; if ({bus60.dec10, bus60.dec1, bus60.load_err} !== {8'h12, 1'b0}) begin
         failures++; $display("FAIL load12: got %h%h e=%b want 12 e=0", bus60.dec10, bus60.dec1, bus60.load_err); end
      drive(0, 1'b1, 1'b0, 4'd6, 4'd7);
      checks++; if ({bus60.dec10, bus60.dec1, bus60.load_err, bus60.wrap} !== {8'h12, 2'b10}) begin
         failures++; $display("FAIL load67_reject: got %h%h e=%b w=%b want 12 e=1 w=0",
            bus60.dec10, bus60.dec1, bus60.load_err, bus60.wrap); end
      drive(0, 1'b0, 1'b0, 4'd0, 4'd0);
      checks++; if ({bus60.dec10, bus60.dec1, bus60.load_err} !== {8'h12, 1'b0}) begin
         failures++; $display("FAIL load_err_pulse_end: got %h%h e=%b want 12 e=0", bus60.dec10, bus60.dec1, bus60.load_err); end
      drive(0, 1'b1, 1'b0, 4'hA, 4'd0);
      checks++; if ({bus60.dec10, bus60.dec1, bus60.load_err} !== {8'h12, 1'b1}) begin
         failures++; $display("FAIL loadA0_reject: got %h%h e=%b want 12 e=1", bus60.dec10, bus60.dec1, bus60.load_err); end
      drive(0, 1'b1, 1'b0, 4'd0, 4'hA);
      checks++; if ({bus60.dec10, bus60.dec1, bus60.load_err} !== {8'h12, 1'b1}) begin
         failures++; $display("FAIL load0A_reject: got %h%h e=%b want 12 e=1", bus60.dec10, bus60.dec1, bus60.load_err); end
      drive(1, 1'b1, 1'b0, 4'd2, 4'd4);
      checks++; if ({bus24.dec10, bus24.dec1, bus24.load_err} !== {8'h23, 1'b1}) begin
         failures++; $display("FAIL hour_load24_reject: got %h%h e=%b want 23 e=1", bus24.dec10, bus24.dec1, bus24.load_err); end
   endtask

   task automatic test_simultaneous();
      bus60.up_down = 1'b1;
      drive(0, 1'b1, 1'b0, 4'd5, 4'd9);
      checks++; if ({bus60.dec10, bus60.dec1, bus60.load_err} !== {8'h59, 1'b0}) begin
         failures++; $display("FAIL load59: got %h%h e=%b want 59 e=0", bus60.dec10, bus60.dec1, bus60.load_err); end
      drive(0, 1'b1, 1'b1, 4'd3, 4'd0);
      checks++; if ({bus60.dec10, bus60.dec1, bus60.wrap} !== {8'h30, 1'b0}) begin
         failures++; $display("FAIL load_beats_tick: got %h%h w=%b want 30 w=0", bus60.dec10, bus60.dec1, bus60.wrap); end
      bus60.hold = 1'b1;
      for (int i = 0; i < 5; i++) begin
         drive(0, 1'b0, 1'b1, 4'd0, 4'd0);
         checks++; if ({bus60.dec10, bus60.dec1, bus60.wrap} !== {8'h30, 1'b0}) begin
            failures++; $display("FAIL hold_tick%0d: got %h%h w=%b want 30 w=0", i, bus60.dec10, bus60.dec1, bus60.wrap); end
      end
      drive(0, 1'b1, 1'b0, 4'd4, 4'd4);
      checks++; if ({bus60.dec10, bus60.dec1} !== 8'h44) begin
         failures++; $display("FAIL load_under_hold: got %h%h want 44", bus60.dec10, bus60.dec1); end
      bus60.hold = 1'b0;
   endtask

   task automatic test_cascade();
      int sec_wraps;
      int min_wraps;
      sec_wraps = 0;
      min_wraps = 0;
      pulse_reset();
      bus60.up_down = 1'b1;
      bus60.tick = 1'b1;
      for (int i = 0; i < 3600; i++) begin
         @(negedge clk);
         if (bus60.wrap === 1'b1) sec_wraps++;
         if (bus_min.wrap === 1'b1) min_wraps++;
         if (i == 1799) begin
            checks++; if ({bus_min.dec10, bus_min.dec1, bus60.dec10, bus60.dec1, bus60.wrap} !== {16'h2900, 1'b1}) begin
               failures++; $display("FAIL cascade_mid: got %h%h:%h%h w=%b want 29:00 w=1",
                  bus_min.dec10, bus_min.dec1, bus60.dec10, bus60.dec1, bus60.wrap); end
         end
      end
      bus60.tick = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (bus60.wrap === 1'b1) sec_wraps++;
         if (bus_min.wrap === 1'b1) min_wraps++;
      end
      $display("txn cascade 3600 ticks -> %h%h:%h%h sec_wraps=%0d min_wraps=%0d",
               bus_min.dec10, bus_min.dec1, bus60.dec10, bus60.dec1, sec_wraps, min_wraps);
      checks++; if ({bus_min.dec10, bus_min.dec1, bus60.dec10, bus60.dec1} !== 16'h0000) begin
         failures++; $display("FAIL cascade_final: got %h%h:%h%h want 00:00",
            bus_min.dec10, bus_min.dec1, bus60.dec10, bus60.dec1); end
      checks++; if (min_wraps !== 1) begin
         failures++; $display("FAIL cascade_upper_wraps: got %0d want 1", min_wraps); end
      checks++; if (sec_wraps !== 60) begin
         failures++; $display("FAIL cascade_lower_wraps: got %0d want 60", sec_wraps); end
   endtask

   task automatic test_reset_mid();
      bus60.up_down = 1'b1;
      drive(0, 1'b1, 1'b0, 4'd5, 4'd9);
      bus60.tick = 1'b1;
      bus24.load_enable = 1'b1; bus24.set_value10 = 4'd2; bus24.set_value1 = 4'd4;
      @(negedge clk);
      bus60.tick = 1'b0;
      bus24.load_enable = 1'b0;
      checks++; if ({bus60.wrap, bus24.load_err} !== 2'b11) begin
         failures++; $display("FAIL mid_pulses_live: got w=%b e=%b want w=1 e=1", bus60.wrap, bus24.load_err); end
      #2;
      reset_p = 1'b1;
      #1;
      checks++; if ({bus60.dec10, bus60.dec1, bus60.wrap, bus60.is_zero} !== {8'h00, 2'b01}) begin
         failures++; $display("FAIL mid_reset_m60: got %h%h w=%b z=%b want 00 w=0 z=1",
            bus60.dec10, bus60.dec1, bus60.wrap, bus60.is_zero); end
      checks++; if ({bus24.dec10, bus24.dec1, bus24.load_err, bus24.is_zero} !== {8'h07, 2'b00}) begin
         failures++; $display("FAIL mid_reset_m24: got %h%h e=%b z=%b want 07 e=0 z=0",
            bus24.dec10, bus24.dec1, bus24.load_err, bus24.is_zero); end
      checks++; if ({bus_min.dec10, bus_min.dec1, bus_min.wrap} !== {8'h00, 1'b0}) begin
         failures++; $display("FAIL mid_reset_min: got %h%h w=%b want 00 w=0", bus_min.dec10, bus_min.dec1, bus_min.wrap); end
      #1;
      reset_p = 1'b0;
      @(negedge clk);
      drive(0, 1'b0, 1'b1, 4'd0, 4'd0);
      checks++; if ({bus60.dec10, bus60.dec1, bus24.dec10, bus24.dec1} !== 16'h0107) begin
         failures++; $display("FAIL first_tick_after_reset: got m60=%h%h m24=%h%h want 01 07",
            bus60.dec10, bus60.dec1, bus24.dec10, bus24.dec1); end
   endtask

   initial begin
      reset_p = 1'b1;
      bus60.tick = 1'b0; bus60.up_down = 1'b1; bus60.hold = 1'b0; bus60.load_enable = 1'b0;
      bus60.set_value1 = 4'd0; bus60.set_value10 = 4'd0;
      bus24.tick = 1'b0; bus24.up_down = 1'b1; bus24.hold = 1'b0; bus24.load_enable = 1'b0;
      bus24.set_value1 = 4'd0; bus24.set_value10 = 4'd0;
      bus_min.hold = 1'b0; bus_min.load_enable = 1'b0;
      bus_min.set_value1 = 4'd0; bus_min.set_value10 = 4'd0;

      test_reset();
      test_up_wrap();
      test_down_wrap();
      test_carry_borrow();
      test_hour();
      test_invalid_load();
      test_simultaneous();
      test_cascade();
      test_reset_mid();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bcd_mod_counter.md
# bcd_mod_counter

Parametrised two-digit BCD counter for the clock/timer datapath. It counts up or down modulo `MODULUS` on single-cycle tick pulses from the clock-divider chain. It supports synchronous preload, hold, and a one-cycle wrap pulse for cascading into the next digit pair. It replaces the fixed mod-60/mod-100 up and down counters with one block that serves seconds, minutes, hours and centiseconds in both stopwatch and countdown modes.

## Interface
- `MODULUS`, 60: count range 0..MODULUS-1. Legal range 2..100.
- `INIT`, 0: value after reset. Must be < MODULUS.
- `clk` input 1: system clock.
- `reset_p` input 1: asynchronous, active-high reset.
- `tick` input 1: one-cycle count-enable pulse from the divider chain.
- `up_down` input 1: 1 = count up, 0 = count down. Sampled with `tick`.
- `hold` input 1: 1 = ignore `tick` (pause). Does not block load.
- `load_enable` input 1: synchronous preload request.
- `set_value1` input 4: ones digit to load.
- `set_value10` input 4: tens digit to load.
- `dec1` output 4: ones digit, BCD.
- `dec10` output 4: tens digit, BCD.
- `wrap` output 1: one-cycle pulse on an up wrap (MODULUS-1→0) or a down wrap (0→MODULUS-1).
- `is_zero` output 1: high while the count equals 0.
- `load_err` output 1: one-cycle pulse when a load is rejected.

## Operation
- Count value V = 10·dec10 + dec1. Always 0 ≤ V ≤ MODULUS-1, and each digit is always 0..9.
- Priority per clk edge is: reset_p, then load_enable, then (tick & ~hold), then idle.
- **Load**
  - A load is valid when set_value1 ≤ 9, set_value10 ≤ 9, and 10·set_value10+set_value1 < MODULUS.
  - Valid load: the digits take the set values.
  - Invalid load: V is unchanged and load_err pulses for 1 cycle.
  - Load never asserts wrap. A tick arriving in the same cycle as a load is dropped.
- **Up count** (tick & ~hold & up_down)
  - If V = MODULUS-1: V←0 and wrap pulses.
  - Otherwise, if dec1 = 9: dec1←0 and dec10←dec10+1.
  - Otherwise dec1←dec1+1.
- **Down count** (tick & ~hold & ~up_down)
  - If V = 0: V←MODULUS-1 and wrap pulses. The digits are (MODULUS-1)/10 and (MODULUS-1)%10, computed at elaboration.
  - Otherwise, if dec1 = 0: dec1←9 and dec10←dec10-1.
  - Otherwise dec1←dec1-1.
- **Direction changes** take effect on the next tick. There is no internal state besides the digits.
- **Outputs**
  - wrap and load_err are registered. They are 0 in every cycle that has no wrap or rejection event; neither signal is sticky.
  - is_zero is combinational from the registered digits.
- **Cascading:** the next stage connects `tick` ← this stage's `wrap` and uses the same `up_down`. This gives borrow/carry chaining of sec→min→hour.

## Timing
- **Reset:** asynchronous, with immediate effect. dec10/dec1 = INIT/10 and INIT%10, wrap=0, load_err=0. is_zero follows (INIT==0).
- **Reset mid-operation:** any in-flight wrap or load_err pulse is cleared in the same instant. The first count occurs on the first tick edge after reset_p deasserts.
- **Latency:** 1 clk. The count, wrap and load_err update on the edge that samples tick or load_enable high, and are visible the following cycle.
- **wrap:** high for exactly one clk per wrapping tick, and coincides with the wrapped value.
- **Cascade latency:** a chained stage updates 1 clk after this stage.
- **tick held high:** if tick stays high for N consecutive cycles, that is N counts. The divider chain guarantees single-cycle pulses.
- **hold:** hold=1 with tick=1 means no change and no wrap.
- **Simultaneous load_enable and tick:** the load wins, with no wrap, even if the tick would have wrapped.

## Test plan
- **Up wrap:** MODULUS=60, load 5/8 (V=58), up, 2 ticks → 59, then 00 with wrap=1 for 1 clk and is_zero=1.
- **Down wrap:** MODULUS=60, reset (00), down, 1 tick → 59 with wrap=1 for 1 clk. A second tick → 58 with wrap=0.
- **Hour modulus:** MODULUS=24, load 2/3 (V=23), up tick → 00 with wrap. Then down tick → 23 with wrap.
- **Invalid load:** MODULUS=60, V=12, load 6/7 (V=67) → stays 12 and load_err=1 for 1 clk. Load digit A/0 → also rejected.
- **Simultaneous events:** V=59 up, load 3/0 and tick in the same cycle → 30, wrap=0. hold=1 with 5 ticks → unchanged.
- **Cascade and reset:** two instances (MODULUS=60 each) chained via wrap, 3600 ticks up → 00:00 with exactly one upper-stage wrap. Assert reset_p mid-count → immediately INIT with pulses cleared.
